spi_top: RTL and testbench

// - APB-slave-fronted SPI master: each APB access runs one 32-bit SPI transaction to one of two slaves.
// - Sits between the system APB bus and the off-chip SPI pins; the APB access completes only when the SPI frame completes.
// - Writes shift PWDATA out on mosi; reads shift 32 bits in from miso and return them on PRDATA.

---
 rtl/spi_pkg.sv | 7 +
 rtl/spi_shifter.sv | 57 +++++
 rtl/spi_top.sv | 65 ++++++
 tb/tb_spi_top.sv | 117 +++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI master types, slave addresses and default frame width
package spi_pkg;
  localparam int DATA_W = 32;
  localparam logic [2:0] ADDR_SS0 = 3'b100;
  localparam logic [2:0] ADDR_SS1 = 3'b010;
  typedef enum logic [1:0] {IDLE, SETUP, XFER, DONE} state_t;
endpackage

// File: rtl/spi_shifter.sv
// spi_shifter: mode-0 frame engine (start loads wdata, dir gates mosi, done flags the last falling sclk edge, rdata is the received word)
module spi_shifter #(
  parameter int DATA_W = 32,
  parameter int CLK_HALF = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dir,
  input  logic [DATA_W-1:0] wdata,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic              done,
  output logic [DATA_W-1:0] rdata
);
  localparam int CW = $clog2(DATA_W) + 1;
  localparam int DW = $clog2(CLK_HALF) + 1;
  logic [DATA_W-1:0] sh;
  logic [CW-1:0] cnt;
  logic [DW-1:0] div;
  logic rb, pend, run, tick;
  assign tick = run && div == DW'(CLK_HALF - 1);
  assign done = tick && sclk && cnt == CW'(DATA_W);
  assign mosi = dir && (pend || run) && sh[DATA_W-1];
  assign rdata = {sh[DATA_W-2:0], rb};
  always_ff @(posedge clk) begin
    if (rst) begin
      sh <= '0;
      cnt <= '0;
      div <= '0;
      rb <= 1'b0;
      pend <= 1'b0;
      run <= 1'b0;
      sclk <= 1'b0;
    end else begin
      pend <= start;
      if (start) begin
        sh <= wdata;
        cnt <= '0;
        div <= '0;
      end
      if (pend) run <= 1'b1;
      if (run) begin
        div <= tick ? '0 : div + 1'b1;
        if (tick) begin
          sclk <= ~sclk;
          if (!sclk) begin
            rb <= miso;
            cnt <= cnt + 1'b1;
          end else sh <= rdata;
          if (done) run <= 1'b0;
        end
      end
    end
  end
endmodule

// File: rtl/spi_top.sv
// spi_top: APB slave that runs one SPI frame per access (APB in, PREADY/PRDATA out, ss0/ss1/sclk/mosi to the pins)
module spi_top #(
  parameter int DATA_W = spi_pkg::DATA_W,
  parameter int CLK_HALF = 1
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic [2:0]        PADDR,
  input  logic              PWRITE,
  input  logic [DATA_W-1:0] PWDATA,
  input  logic              miso,
  output logic              PREADY,
  output logic [DATA_W-1:0] PRDATA,
  output logic              ss0,
  output logic              ss1,
  output logic              sclk,
  output logic              mosi
);
  import spi_pkg::*;
  state_t st, nx;
  logic wr, sel, acc, vld, start, done, act;
  logic [DATA_W-1:0] rdata;
  assign acc = PSEL && PENABLE;
  assign vld = PADDR == ADDR_SS0 || PADDR == ADDR_SS1;
  assign start = st == IDLE && acc && vld;
  assign act = st == SETUP || st == XFER;
  assign PREADY = st == DONE;
  assign ss0 = !(act && !sel);
  assign ss1 = !(act && sel);
  always_comb begin
    nx = st == IDLE ? (acc ? (vld ? SETUP : DONE) : IDLE) :
         st == SETUP ? XFER :
         st == XFER ? (done ? DONE : XFER) : IDLE;
  end
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      st <= IDLE;
      wr <= 1'b0;
      sel <= 1'b0;
      PRDATA <= '0;
    end else begin
      st <= nx;
      if (start) begin
        wr <= PWRITE;
        sel <= PADDR == ADDR_SS1;
      end
      if (st == IDLE && acc && !vld) PRDATA <= '0;
      if (done && !wr) PRDATA <= rdata;
    end
  end
  spi_shifter #(.DATA_W(DATA_W), .CLK_HALF(CLK_HALF)) u_shifter (
    .clk(PCLK),
    .rst(PRESET),
    .start(start),
    .dir(wr),
    .wdata(PWDATA),
    .miso(miso),
    .sclk(sclk),
    .mosi(mosi),
    .done(done),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_spi_top.sv
// tb_spi_top: directed scoreboard bench for spi_top
module tb_spi_top;
  logic PCLK = 1'b0, PRESET = 1'b1, PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0, miso = 1'b0;
  logic [2:0] PADDR = 3'b000;
  logic [31:0] PWDATA = 32'h0;
  logic PREADY, ss0, ss1, sclk, mosi;
  logic [31:0] PRDATA;
  int checks = 0, errors = 0;
  logic [31:0] rd_q[$], tx_q[$];
  logic [31:0] last_rd = 32'h0;
  spi_top dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .miso(miso), .PREADY(PREADY), .PRDATA(PRDATA),
    .ss0(ss0), .ss1(ss1), .sclk(sclk), .mosi(mosi)
  );
  always #5 PCLK = ~PCLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // Cycle 1 is the SETUP cycle after the access phase is sampled, so DONE lands on cycle 66.
  task automatic frame(input logic [2:0] a, input logic w, input logic [31:0] wd, input bit ones,
                       input int abort_at, input string nm);
    bit valid, s1, got, quiet;
    int cyc, rises, lowsel, lowoth;
    logic [31:0] txw, exp_rx, e;
    logic prev, many;
    valid = a == 3'b100 || a == 3'b010;
    s1 = a == 3'b010;
    exp_rx = ones ? 32'hFFFF_FFFF : 32'hAAAA_AAAA;
    got = 0; cyc = 0; rises = 0; lowsel = 0; lowoth = 0; txw = 0; prev = 0; many = 0;
    if (abort_at < 0) begin
      tx_q.push_back((valid && w) ? wd : 32'h0);
      rd_q.push_back(!valid ? 32'h0 : w ? last_rd : exp_rx);
    end
    @(negedge PCLK);
    PSEL = 1; PENABLE = 0; PADDR = a; PWRITE = w; PWDATA = wd; miso = 1;
    @(negedge PCLK);
    PENABLE = 1;
    @(posedge PCLK);
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge PCLK);
      cyc++;
      if (i == 3) begin
        PWDATA = ~wd;
        PADDR = s1 ? 3'b100 : 3'b010;
      end
      if (sclk && !prev) begin
        txw = {txw[30:0], mosi};
        rises++;
      end
      prev = sclk;
      many |= mosi;
      if ((s1 ? ss1 : ss0) == 1'b0) lowsel++;
      if ((s1 ? ss0 : ss1) == 1'b0) lowoth++;
      miso = ones ? 1'b1 : ~rises[0];
      if (abort_at >= 0 && rises == abort_at) break;
      if (PREADY) got = 1;
    end
    if (abort_at >= 0) begin
      PRESET = 1;
      @(negedge PCLK);
      chk({nm, "_ss0"}, {31'h0, ss0}, 32'h1);
      chk({nm, "_ss1"}, {31'h0, ss1}, 32'h1);
      chk({nm, "_sclk"}, {31'h0, sclk}, 32'h0);
      chk({nm, "_ready"}, {31'h0, PREADY}, 32'h0);
      chk({nm, "_prdata"}, PRDATA, 32'h0);
      last_rd = 32'h0;
      PRESET = 0; PSEL = 0; PENABLE = 0;
      quiet = 1;
      repeat (5) begin
        @(negedge PCLK);
        if (PREADY || !ss0 || !ss1 || sclk) quiet = 0;
      end
      chk({nm, "_quiet"}, {31'h0, quiet}, 32'h1);
    end else begin
      chk({nm, "_got_ready"}, {31'h0, got}, 32'h1);
      chk({nm, "_latency"}, cyc, valid ? 32'd66 : 32'd1);
      chk({nm, "_sclk_pulses"}, rises, valid ? 32'd32 : 32'd0);
      chk({nm, "_sel_low_cycles"}, lowsel, valid ? 32'd65 : 32'd0);
      chk({nm, "_other_ss_low"}, lowoth, 32'd0);
      chk({nm, "_mosi_any"}, {31'h0, many}, {31'h0, valid && w});
      e = tx_q.pop_front();
      chk({nm, "_mosi_word"}, txw, e);
      e = rd_q.pop_front();
      chk({nm, "_prdata"}, PRDATA, e);
      last_rd = e;
      PSEL = 0; PENABLE = 0;
      @(negedge PCLK);
      chk({nm, "_ready_drop"}, {31'h0, PREADY}, 32'h0);
    end
  endtask
  initial begin
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    chk("rst_ss0", {31'h0, ss0}, 32'h1);
    chk("rst_ss1", {31'h0, ss1}, 32'h1);
    chk("rst_sclk", {31'h0, sclk}, 32'h0);
    chk("rst_mosi", {31'h0, mosi}, 32'h0);
    chk("rst_ready", {31'h0, PREADY}, 32'h0);
    chk("rst_prdata", PRDATA, 32'h0);
    PRESET = 0;
    frame(3'b100, 1'b1, 32'hAAAA_FAEB, 1'b0, -1, "wr_ss0");
    frame(3'b100, 1'b0, 32'h0, 1'b0, -1, "rd_ss0");
    frame(3'b010, 1'b1, 32'hF0F0_F0F0, 1'b0, -1, "wr_ss1");
    frame(3'b010, 1'b0, 32'h0, 1'b1, -1, "rd_ss1");
    frame(3'b001, 1'b1, 32'h1234_5678, 1'b0, -1, "bad_addr");
    frame(3'b100, 1'b1, 32'h1234_5678, 1'b0, 10, "abort");
    frame(3'b100, 1'b1, 32'hAAAA_FAEB, 1'b0, -1, "post_wr");
    frame(3'b010, 1'b0, 32'h0, 1'b0, -1, "post_rd");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
